range_seq_driver: RTL

- Transmit end of the go/finish range-measurement stream protocol.
- A host pushes framed data words into an internal buffer. For each complete frame, the block drives a gap-free burst to a range-measurement receiver: go on the first word, data every cycle, finish on the last word.
- It captures the receiver's range result and monitors the receiver's error output.
- Sits between a host/loader and the range-measurement block; both share clock and reset.

---
 rtl/range_pkg.sv | 29 ++
 rtl/range_seq_driver_if.sv | 41 ++++
 rtl/range_fifo.sv | 73 +++++++
 rtl/range_seq_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// ============================================================================
//  Module      : range_pkg
//  Description : Shared types and defaults for the go/finish range-measurement
//                stream driver (data width, driver states, buffer entry).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package range_pkg;

    // Default data word width
    localparam int DATA_W = 8;

    // Driver FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DUP  = 2'd2
    } drv_state_e;

    // One buffered host word with its frame-end marker
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/range_seq_driver_if.sv
// ============================================================================
//  Module      : range_seq_driver_if
//  Description : Host write channel and receiver stream channel of the
//                range-measurement stream driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface range_seq_driver_if
    import range_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    // Host write channel
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic             wr_valid;
    logic             wr_ready;

    // Receiver stream channel
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] range_in;
    logic             error_in;

    // Driver side
    modport slave (
        input  wr_data, wr_last, wr_valid, range_in, error_in,
        output wr_ready, data_out, go, finish
    );

    // Host / receiver side
    modport master (
        output wr_data, wr_last, wr_valid, range_in, error_in,
        input  wr_ready, data_out, go, finish
    );

endinterface

`default_nettype wire

// File: rtl/range_fifo.sv
// ============================================================================
//  Module      : range_fifo
//  Description : Synchronous FIFO with flush, full/empty flags and occupancy
//                count. Read data is the current head (show-ahead).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     flush,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never accepts, even in a cycle that pops (no bypass)
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign count = occ;
    assign dout  = mem[rd_ptr];

    // Storage array write
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/range_seq_driver.sv
// ============================================================================
//  Module      : range_seq_driver
//  Description : Buffers framed host words and replays each complete frame as
//                a gap-free go/data/finish burst to a range-measurement
//                receiver; captures the range result and error status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_seq_driver
    import range_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    range_seq_driver_if.slave     bus,
    output logic      [WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  rx_err,
    output logic                  ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_SEND = ST_SEND;
    localparam logic [1:0] S_DUP  = ST_DUP;

    logic [1:0]       state;
    logic [CW-1:0]    frames_pending;
    logic             dropping;

    logic [WIDTH-1:0] drv_data;
    logic             drv_go;
    logic             drv_finish;

    logic [WIDTH:0]   fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             head_last;
    logic [WIDTH-1:0] head_data;

    logic             accept;
    logic             push;
    logic             pop;
    logic             start;
    logic             inc;
    logic             overflow;

    assign head_last = fifo_dout[WIDTH];
    assign head_data = fifo_dout[WIDTH-1:0];

    // Host handshake: words of an oversized frame are accepted but dropped
    assign bus.wr_ready = ~fifo_full & ~reset;
    assign accept       = bus.wr_valid & bus.wr_ready;
    assign push         = accept & ~dropping;
    assign inc          = push & bus.wr_last;

    // A full buffer holding no complete frame can never drain
    assign overflow = (fifo_count == CW'(DEPTH)) && (frames_pending == '0);

    // A frame only starts once fully buffered, so SEND pops never underflow
    assign start = (state == S_IDLE) && (frames_pending != '0);
    assign pop   = start | (state == S_SEND);

    assign bus.data_out = drv_data;
    assign bus.go       = drv_go;
    assign bus.finish   = drv_finish;
    assign busy         = (state != S_IDLE) | drv_finish;

    range_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (overflow),
        .din   ({bus.wr_last, bus.wr_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Count of complete frames sitting in the buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frames_pending <= '0;
        end else if (inc && !start) begin
            frames_pending <= frames_pending + CW'(1);
        end else if (start && !inc) begin
            frames_pending <= frames_pending - CW'(1);
        end
    end

    // Discard the tail of an oversized frame up to and including its last word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dropping <= 1'b0;
        end else if (overflow) begin
            dropping <= 1'b1;
        end else if (accept && bus.wr_last) begin
            dropping <= 1'b0;
        end
    end

    // Burst sequencer; single-word frames re-drive the word to keep go and
    // finish in separate cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            drv_data   <= '0;
            drv_go     <= 1'b0;
            drv_finish <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    drv_finish <= 1'b0;
                    drv_go     <= 1'b0;
                    if (start) begin
                        drv_data <= head_data;
                        drv_go   <= 1'b1;
                        state    <= head_last ? S_DUP : S_SEND;
                    end
                end
                S_SEND: begin
                    drv_go   <= 1'b0;
                    drv_data <= head_data;
                    if (head_last) begin
                        drv_finish <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DUP: begin
                    drv_go     <= 1'b0;
                    drv_finish <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    drv_go     <= 1'b0;
                    drv_finish <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the receiver's range on each finish cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= drv_finish;
            if (drv_finish) begin
                result <= bus.range_in;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_err  <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            rx_err  <= rx_err | bus.error_in;
            ovf_err <= ovf_err | overflow;
        end
    end

    // Buffer emptiness is implied by frames_pending; kept for observability
    logic unused_ok;
    assign unused_ok = fifo_empty;

endmodule

`default_nettype wire
